// File: rtl/latch_wr_sched.sv
// ---------------------------------------------------------------------------
// latch_wr_sched
//
// Round-robin write scheduler that lets N_REQ requesters share a single
// transparent D latch bank. A winner is picked in IDLE, its data slice is
// registered onto d_o, and the latch gate le_o is then run through a fixed
// setup / open / hold sequence so the latch input never moves while the
// gate is open. Completion is reported back with a one-cycle done pulse.
//
// Ports:
//   clk_i    : single clock, rising edge
//   rst_i    : synchronous active-high reset
//   req_i    : per-requester write request (level)
//   data_i   : write data, requester k at [k*WIDTH +: WIDTH]
//   gnt_o    : one-hot grant, held from SETUP through DONE
//   done_o   : one-hot, one-cycle completion pulse in DONE
//   le_o     : latch gate to the bank
//   d_o      : registered latch data to the bank
//   busy_o   : high whenever the scheduler is not idle
//   owner_o  : index of the current or most recent winner
// ---------------------------------------------------------------------------
module latch_wr_sched #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 8,
   parameter int OPEN_CYCLES = 2,
   localparam int OW         = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] data_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       done_o,
   output logic                   le_o,
   output logic [WIDTH-1:0]       d_o,
   output logic                   busy_o,
   output logic [OW-1:0]          owner_o
);

   localparam int CW = $clog2(OPEN_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_OPEN,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [OW-1:0]     last_winner, last_nxt;
   logic [N_REQ-1:0]  gnt_nxt, done_nxt;
   logic              le_nxt, busy_nxt;
   logic [WIDTH-1:0]  d_nxt;
   logic [OW-1:0]     owner_nxt;
   logic              found;
   logic [OW-1:0]     win, cand;

   // All outputs are registered: the combinational block below computes the
   // next value of every output together with the next state, and this
   // block simply captures them. Reset closes the latch immediately, which
   // also aborts any write in flight without a done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         last_winner <= OW'(N_REQ - 1);
         gnt_o       <= '0;
         done_o      <= '0;
         le_o        <= 1'b0;
         d_o         <= '0;
         busy_o      <= 1'b0;
         owner_o     <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         last_winner <= last_nxt;
         gnt_o       <= gnt_nxt;
         done_o      <= done_nxt;
         le_o        <= le_nxt;
         d_o         <= d_nxt;
         busy_o      <= busy_nxt;
         owner_o     <= owner_nxt;
      end
   end

   // Round-robin search: walk the requesters starting just after the last
   // winner and wrapping around, keeping the first one found. Doing this
   // every cycle is harmless since the result is only used in IDLE.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = OW'((int'(last_winner) + i) % N_REQ);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state and next-output logic. Data is only sampled on the
   // IDLE->SETUP transition, so d_o is frozen for the whole gate sequence.
   // The gate is raised when leaving SETUP and dropped when the open
   // down-counter reaches its last cycle, giving exactly OPEN_CYCLES high.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last_winner;
      gnt_nxt   = gnt_o;
      done_nxt  = '0;
      le_nxt    = 1'b0;
      d_nxt     = d_o;
      owner_nxt = owner_o;

      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nxt = ST_SETUP;
               gnt_nxt   = N_REQ'(1) << win;
               owner_nxt = win;
               d_nxt     = data_i[int'(win)*WIDTH +: WIDTH];
            end
         end
         ST_SETUP: begin
            state_nxt = ST_OPEN;
            le_nxt    = 1'b1;
            cnt_nxt   = CW'(OPEN_CYCLES);
         end
         ST_OPEN: begin
            if (cnt == CW'(1)) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end else begin
               le_nxt  = 1'b1;
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            state_nxt = ST_DONE;
            done_nxt  = gnt_o;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            last_nxt  = owner_o;
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_latch_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_latch_wr_sched
//
// Self-checking bench for latch_wr_sched (N_REQ=4, WIDTH=8, OPEN_CYCLES=2).
// A transaction-level reference model tracks whether a write is in flight,
// how many cycles have passed since its grant, who owns it and which data
// was captured; every cycle all DUT outputs are compared against what that
// model implies. Directed sequences exercise reset, fairness, priority wrap,
// data stability and reset mid-write, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_latch_wr_sched;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int OC = 2;
   localparam int OW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   data;
   logic [N-1:0]     gnt;
   logic [N-1:0]     done;
   logic             le;
   logic [W-1:0]     d;
   logic             busy;
   logic [OW-1:0]    owner;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state: a write is either idle or "age" cycles past its grant.
   bit               m_active;
   int               m_age;
   int               m_owner;
   int               m_last;
   logic [W-1:0]     m_data;

   always #5 clk = ~clk;

   latch_wr_sched #(
      .N_REQ       (N),
      .WIDTH       (W),
      .OPEN_CYCLES (OC)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .data_i  (data),
      .gnt_o   (gnt),
      .done_o  (done),
      .le_o    (le),
      .d_o     (d),
      .busy_o  (busy),
      .owner_o (owner)
   );

   // Count one comparison and report it if observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance the reference model by one clock edge using the sampled inputs.
   task automatic model_step();
      int idx;
      if (rst) begin
         m_active = 1'b0;
         m_age    = 0;
         m_owner  = 0;
         m_last   = N - 1;
         m_data   = '0;
      end else if (m_active) begin
         if (m_age == OC + 2) begin
            m_active = 1'b0;
            m_last   = m_owner;
         end else begin
            m_age++;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (req[idx]) begin
               m_owner  = idx;
               m_data   = data[idx*W +: W];
               m_active = 1'b1;
               m_age    = 0;
               break;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, step the model on the edge, then compare all
   // outputs shortly after the edge.
   task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] dv, input logic rs);
      req  = r;
      data = dv;
      rst  = rs;
      @(posedge clk);
      model_step();
      #1;
      checkOutput("gnt",   gnt,   m_active ? (32'd1 << m_owner) : 32'd0);
      checkOutput("done",  done,  (m_active && m_age == OC + 2) ? (32'd1 << m_owner) : 32'd0);
      checkOutput("le",    le,    (m_active && m_age >= 1 && m_age <= OC) ? 32'd1 : 32'd0);
      checkOutput("busy",  busy,  m_active ? 32'd1 : 32'd0);
      checkOutput("owner", owner, m_owner);
      checkOutput("d",     d,     m_data);
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Hold a request pattern, each requester dropping on its done pulse, and
   // verify the order in which grants are issued (nibble k = k-th winner).
   task automatic run_seq(input string tag, input logic [N-1:0] start_req,
                          input logic [15:0] exp_order, input int n_exp);
      logic [N-1:0] cur;
      logic [N-1:0] prev_gnt;
      int           n_got;
      cur      = start_req;
      prev_gnt = '0;
      n_got    = 0;
      for (int c = 0; c < n_exp * (OC + 4) + 4; c++) begin
         applyStimulus(cur, $urandom, 1'b0);
         if (gnt != '0 && prev_gnt == '0) begin
            if (n_got < n_exp) checkOutput(tag, onehot_idx(gnt), exp_order[4*n_got +: 4]);
            n_got++;
         end
         prev_gnt = gnt;
         cur      = cur & ~done;
      end
      checkOutput({tag, "_count"}, n_got, n_exp);
   endtask

   initial begin
      logic [N*W-1:0] dv;
      logic [N-1:0]   cur;
      int             le_count;

      // Reset state
      applyStimulus('0, '0, 1'b1);
      applyStimulus('0, '0, 1'b1);
      checkOutput("rst_le",    le,    0);
      checkOutput("rst_busy",  busy,  0);
      checkOutput("rst_owner", owner, 0);
      checkOutput("rst_d",     d,     0);
      applyStimulus('0, $urandom, 1'b0);

      // Fairness from reset, then again continuing after requester 3
      run_seq("rr_first",  4'b1111, 16'h3210, 4);
      run_seq("rr_second", 4'b1111, 16'h3210, 4);

      // Priority wrap: last winner 3, requesters 0 and 3 active
      run_seq("wrap", 4'b1001, 16'h0030, 2);

      // Single write from requester 2 with 0xA5
      dv = $urandom;
      dv[23:16] = 8'hA5;
      applyStimulus(4'b0100, dv, 1'b0);
      checkOutput("single_gnt", gnt, 4'b0100);
      checkOutput("single_d",   d,   8'hA5);
      le_count = 0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus('0, $urandom, 1'b0);
         le_count += int'(le);
         if (i == 4) checkOutput("single_done", done, 4'b0100);
      end
      checkOutput("single_le_cnt",   le_count, 2);
      checkOutput("single_busy_end", busy,     0);

      // Data stability: owner data toggles every cycle, request dropped in OPEN
      dv = $urandom;
      dv[15:8] = 8'h3C;
      applyStimulus(4'b0010, dv, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus((i <= 1) ? 4'b0010 : 4'b0000, $urandom, 1'b0);
         checkOutput("stab_d", d, 8'h3C);
         if (i == 4) checkOutput("stab_done", done, 4'b0010);
      end

      // Reset in the second OPEN cycle aborts the write without done
      applyStimulus(4'b0100, $urandom, 1'b0);
      applyStimulus('0, $urandom, 1'b0);
      applyStimulus('0, $urandom, 1'b0);
      checkOutput("abort_le_open", le, 1);
      applyStimulus('0, $urandom, 1'b1);
      checkOutput("abort_le",   le,   0);
      checkOutput("abort_gnt",  gnt,  0);
      checkOutput("abort_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, $urandom, 1'b0);
         checkOutput("abort_no_done", done, 0);
      end
      applyStimulus(4'b0011, $urandom, 1'b0);
      checkOutput("abort_regrant", gnt, 4'b0001);
      for (int i = 0; i < 6; i++) applyStimulus('0, $urandom, 1'b0);

      // Randomized traffic with occasional resets
      cur = '0;
      for (int c = 0; c < 600; c++) begin
         applyStimulus(cur, $urandom, ($urandom_range(0, 79) == 0));
         cur = cur & ~done;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) cur[i] = 1'b1;
            else if ($urandom_range(0, 11) == 0) cur[i] = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/latch_wr_sched.md
# latch_wr_sched

Round-robin write scheduler that shares one transparent D latch bank (WIDTH bits, active-high gate) between N_REQ requesters. It arbitrates requests and captures the winner's data into a register. It then runs a fixed setup / open / hold sequence on the latch gate, so latch data never changes while the gate is open. It sits between the requesting blocks and the latch bank: it drives the bank's clock/gate and data inputs and reports completion to each requester.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, latch bank data width (>=1)
- OPEN_CYCLES, 2, cycles the latch gate is held high per write (>=1)
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  reset, synchronous, active-high
- req_i  input  N_REQ  write request per requester, level
- data_i  input  N_REQ*WIDTH  write data; requester k occupies bits [k*WIDTH +: WIDTH]
- gnt_o  output  N_REQ  one-hot grant, high from SETUP through DONE
- done_o  output  N_REQ  one-hot, one-cycle pulse when the owner's write completes
- le_o  output  1  latch gate to the bank (connects to the latch clock input)
- d_o  output  WIDTH  latch data to the bank, registered
- busy_o  output  1  high in every state except IDLE
- owner_o  output  max(1,$clog2(N_REQ))  index of the current or last winner

## Operation
- States: IDLE, SETUP, OPEN, HOLD, DONE. All outputs are registered.
- IDLE
  - If any req_i bit is high, choose a winner round-robin. Search starts at index (last_winner+1) mod N_REQ, ascending with wrap.
  - Capture the winner's data_i slice into d_o. Set gnt_o[winner] and owner_o. Go to SETUP.
  - No request: stay in IDLE.
- SETUP: le_o=0, d_o stable. One cycle, then OPEN.
- OPEN
  - le_o=1 for exactly OPEN_CYCLES cycles, counted with a down-counter of width $clog2(OPEN_CYCLES+1).
  - d_o does not change. Then HOLD.
- HOLD: le_o=0, d_o held stable for one cycle (latch hold margin). Then DONE.
- DONE: done_o[owner]=1 and gnt_o still asserted, for one cycle. Then IDLE, where gnt_o clears and last_winner is set to owner.
- Data is taken only at grant. Changes on data_i after grant have no effect.
- A requester deasserting req_i after grant does not abort its transaction; the sequence always completes.
- Non-granted requesters wait with req_i held; nothing is queued beyond the live req_i levels.
- A req_i still high in the IDLE cycle after DONE is a new request. Requesters drop req_i on seeing done_o.
- last_winner resets to N_REQ-1, so requester 0 has first priority after reset.
- d_o retains its last value in IDLE (the latch is closed, so the value is irrelevant but must not toggle).

## Timing
- Reset values (effective the cycle after rst_i is sampled high): state=IDLE, le_o=0, d_o=0, gnt_o=0, done_o=0, busy_o=0, owner_o=0, last_winner=N_REQ-1.
- rst_i high mid-sequence, including during OPEN: le_o=0 at the next edge. No done_o is issued for the aborted write.
- Latency:
  - req_i sampled high in IDLE at edge T: gnt_o and busy_o high after T, le_o rises after T+1.
  - le_o falls after T+1+OPEN_CYCLES; done_o pulses in cycle T+3+OPEN_CYCLES.
- Occupancy is OPEN_CYCLES+3 cycles busy plus one IDLE cycle. Best-case throughput is one write per OPEN_CYCLES+4 cycles.
- le_o is never high in the same cycle d_o changes. d_o changes only on the IDLE->SETUP edge.
- gnt_o and done_o are always one-hot or zero. done_o is high only in DONE.

## Test plan
- Reset during OPEN: OPEN_CYCLES=2, rst_i=1 in second OPEN cycle -> next cycle le_o=0, gnt_o=0, busy_o=0, no done_o; then req_i=0001 -> requester 0 is granted.
- Single write: N_REQ=4, WIDTH=8, req_i=0100, data slice 2=0xA5 -> gnt_o=0100 one cycle later, d_o=0xA5, le_o high exactly 2 cycles, done_o=0100 in cycle T+5, busy_o low at T+6.
- Round-robin fairness: req_i=1111 held for 4 transactions (each requester drops req on done) -> grant order 0,1,2,3; with all reqs re-raised, next order continues 0,1,2,3.
- Priority wrap: last winner 3, req_i=1001 -> requester 0 wins; next with req_i=1001 -> requester 3 wins.
- Data stability: after grant, toggle data_i of the owner every cycle and drop its req_i during OPEN -> d_o constant at the captured value, sequence completes, done_o issued.
- OPEN_CYCLES=1, back-to-back req_i=0011 -> le_o high exactly 1 cycle per write, writes 5 cycles apart, no cycle with le_o=1 while d_o changes.
